// File: rtl/runway_light_scheduler.sv
// runway_light_scheduler: single-clock sequencer for the 3-lamp runway array.
// A prescaler makes a registered one-cycle tick every TICK_DIV cycles. Each
// tick the block picks a pattern: fault on invalid wind, then a pending
// maintenance test, then the wind-selected sweep or calm pattern.
// Optional macro WIND_DEBOUNCE_EN: a new wind value must be seen at two
// consecutive steps before it changes the mode (FAULT entry included).
// Handshake note: there is no valid/ready traffic here. test_req is a level
// or pulse sampled every cycle and latched into test_pending until TEST
// entry consumes it. tick is a pure strobe with no back-pressure.
module runway_light_scheduler #(
  parameter int TICK_DIV   = 25000000,
  parameter int TEST_STEPS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] wind,
  input  logic       test_req,
  input  logic       hold,
  output logic [2:0] lights,
  output logic       tick,
  output logic       busy_test,
  output logic       fault,
  output logic [2:0] dbg_state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    TS       = 8'(TEST_STEPS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALM  = 3'd1,
    S_SWL   = 3'd2,
    S_SWR   = 3'd3,
    S_TEST  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t        state, next_state;
  logic [PW-1:0] prescaler;
  logic [2:0]    next_lights;
  logic [7:0]    test_cnt, next_cnt;
  logic          test_pending, next_pending;
  logic          step;
  logic          req_now;
  logic [1:0]    eff_wind;

  assign busy_test = (state == S_TEST);
  assign fault     = (state == S_FAULT);
  assign dbg_state = state;

  // Prescaler and tick strobe; hold freezes the count and suppresses tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      tick      <= 1'b0;
    end else if (hold) begin
      tick <= 1'b0;
    end else if (prescaler == PRE_LAST) begin
      prescaler <= '0;
      tick      <= 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
      tick      <= 1'b0;
    end
  end

`ifdef WIND_DEBOUNCE_EN
  logic [1:0] prev_wind;
  logic [1:0] mode_wind;

  // Wind value sampled at the previous step, used to reject one-step glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_wind <= 2'b00;
    end else if (step) begin
      prev_wind <= wind;
    end
  end

  // A wind change is only honoured once it has been stable for two steps.
  always_comb begin
    mode_wind = prev_wind;
    case (state)
      S_CALM:  mode_wind = 2'b00;
      S_SWL:   mode_wind = 2'b01;
      S_SWR:   mode_wind = 2'b10;
      S_FAULT: mode_wind = 2'b11;
      default: mode_wind = prev_wind;
    endcase
    eff_wind = (wind == prev_wind) ? wind : mode_wind;
  end
`else
  assign eff_wind = wind;
`endif

  // State, lamp and test-pending registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      lights       <= 3'b000;
      test_cnt     <= 8'd0;
      test_pending <= 1'b0;
    end else begin
      state        <= next_state;
      lights       <= next_lights;
      test_cnt     <= next_cnt;
      test_pending <= next_pending;
    end
  end

  // Step decision: continue TEST, else fault, else pending test, else wind mode.
  always_comb begin
    step         = tick & ~hold;
    req_now      = test_pending | (test_req & (state != S_TEST));
    next_state   = state;
    next_lights  = lights;
    next_cnt     = test_cnt;
    next_pending = req_now;
    if (step) begin
      if ((state == S_TEST) && (eff_wind != 2'b11) && (test_cnt < TS)) begin
        next_cnt    = test_cnt + 8'd1;
        next_lights = test_cnt[0] ? 3'b000 : 3'b111;
      end else if (eff_wind == 2'b11) begin
        next_state  = S_FAULT;
        next_lights = 3'b000;
        next_cnt    = 8'd0;
      end else if (req_now) begin
        next_state   = S_TEST;
        next_lights  = 3'b111;
        next_cnt     = 8'd1;
        next_pending = 1'b0;
      end else begin
        next_cnt = 8'd0;
        case (eff_wind)
          2'b00: begin
            next_state  = S_CALM;
            next_lights = (state == S_CALM) ? ~lights : 3'b101;
          end
          2'b01: begin
            next_state  = S_SWL;
            next_lights = (state == S_SWL) ? {lights[0], lights[2:1]} : 3'b100;
          end
          default: begin
            next_state  = S_SWR;
            next_lights = (state == S_SWR) ? {lights[1:0], lights[2]} : 3'b001;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_runway_light_scheduler.sv
// Bench for runway_light_scheduler with TICK_DIV=4, TEST_STEPS=4.
// A cycle-level reference model tracks mode, phase and pattern tables and
// every output is compared #1 after each rising edge.
module tb_runway_light_scheduler;

  localparam int TD = 4;
  localparam int TSN = 4;

  // Clock and inputs.
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] wind = 2'b00;
  logic       test_req = 1'b0;
  logic       hold = 1'b0;
  logic [2:0] lights;
  logic       tick;
  logic       busy_test;
  logic       fault;
  logic [2:0] dbg_state;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  runway_light_scheduler #(.TICK_DIV(TD), .TEST_STEPS(TSN)) dut (
    .clk(clk), .reset(reset), .wind(wind), .test_req(test_req), .hold(hold),
    .lights(lights), .tick(tick), .busy_test(busy_test), .fault(fault),
    .dbg_state(dbg_state)
  );

  // Reference model. Modes: 0 idle, 1 calm, 2 sweep left, 3 sweep right,
  // 4 test, 5 fault. Lamp values come from pattern tables indexed by phase.
  int         m_cnt = 0;
  bit         m_tick = 0;
  int         m_mode = 0;
  int         m_phase = 0;
  bit         m_pend = 0;
  int         m_tsteps = 0;
  logic [2:0] m_lights = 3'b000;

  function automatic logic [2:0] pat(input int mode, input int ph);
    logic [2:0] calm_t [2];
    logic [2:0] swl_t  [3];
    logic [2:0] swr_t  [3];
    calm_t = '{3'b101, 3'b010};
    swl_t  = '{3'b100, 3'b010, 3'b001};
    swr_t  = '{3'b001, 3'b010, 3'b100};
    case (mode)
      1: return calm_t[ph % 2];
      2: return swl_t[ph % 3];
      3: return swr_t[ph % 3];
      4: return (ph % 2 == 0) ? 3'b111 : 3'b000;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_step(input bit r, input logic [1:0] w, input bit tr, input bit h);
    bit step;
    bit pend_now;
    int want;
    if (r) begin
      m_cnt = 0; m_tick = 0; m_mode = 0; m_phase = 0;
      m_pend = 0; m_tsteps = 0; m_lights = 3'b000;
      return;
    end
    step = m_tick && !h;
    pend_now = m_pend || (tr && m_mode != 4);
    if (step) begin
      if (m_mode == 4 && w != 2'b11 && m_tsteps < TSN) begin
        m_tsteps++;
        m_phase++;
      end else if (w == 2'b11) begin
        m_mode = 5; m_phase = 0;
      end else if (pend_now) begin
        m_mode = 4; m_phase = 0; m_tsteps = 1; pend_now = 0;
      end else begin
        want = int'(w) + 1;
        if (m_mode == want) m_phase++;
        else begin m_mode = want; m_phase = 0; end
      end
      m_lights = pat(m_mode, m_phase);
    end
    m_pend = pend_now;
    if (h) m_tick = 0;
    else if (m_cnt == TD - 1) begin m_cnt = 0; m_tick = 1; end
    else begin m_cnt++; m_tick = 0; end
  endtask

  task automatic check_outputs();
    total++;
    assert (lights === m_lights) else begin
      bad++; $error("FAIL lights obs=%b exp=%b t=%0t", lights, m_lights, $time);
    end
    total++;
    assert (tick === m_tick) else begin
      bad++; $error("FAIL tick obs=%b exp=%b t=%0t", tick, m_tick, $time);
    end
    total++;
    assert (busy_test === (m_mode == 4)) else begin
      bad++; $error("FAIL busy_test obs=%b exp=%b t=%0t", busy_test, (m_mode == 4), $time);
    end
    total++;
    assert (fault === (m_mode == 5)) else begin
      bad++; $error("FAIL fault obs=%b exp=%b t=%0t", fault, (m_mode == 5), $time);
    end
  endtask

  // Driver: apply inputs, advance the model, clock once, compare.
  task automatic cyc(input bit r, input logic [1:0] w, input bit tr, input bit h);
    reset = r; wind = w; test_req = tr; hold = h;
    model_step(r, w, tr, h);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run(input int n, input logic [1:0] w, input bit h);
    for (int i = 0; i < n; i++) cyc(1'b0, w, 1'b0, h);
  endtask

  initial begin
    bit r;
    bit tr;
    bit h;
    logic [1:0] w;
    // Reset, then calm pattern.
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    total++;
    assert (lights === 3'b000 && busy_test === 1'b0 && fault === 1'b0 && tick === 1'b0) else begin
      bad++; $error("FAIL reset_state obs=%b%b%b%b exp=0000", lights, busy_test, fault, tick);
    end
    run(14, 2'b00, 1'b0);
    // Sweep left, then switch to sweep right mid-sequence.
    run(14, 2'b01, 1'b0);
    run(6, 2'b10, 1'b0);
    run(8, 2'b10, 1'b0);
    // Test request, with a second request during TEST that must not repeat.
    run(3, 2'b00, 1'b0);
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    run(6, 2'b00, 1'b0);
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    run(30, 2'b00, 1'b0);
    total++;
    assert (busy_test === 1'b0 && (lights === 3'b101 || lights === 3'b010)) else begin
      bad++; $error("FAIL test_no_repeat obs=%b/%b exp=0/calm", busy_test, lights);
    end
    // Fault, request while faulted, then valid wind.
    run(8, 2'b11, 1'b0);
    cyc(1'b0, 2'b11, 1'b1, 1'b0);
    run(6, 2'b11, 1'b0);
    run(30, 2'b01, 1'b0);
    // Hold mid-calm for 10 cycles, then release.
    run(9, 2'b00, 1'b0);
    run(10, 2'b00, 1'b1);
    run(12, 2'b00, 1'b0);
    // Reset mid-TEST leaves nothing pending.
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    run(6, 2'b00, 1'b0);
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    total++;
    assert (busy_test === 1'b0 && lights === 3'b000) else begin
      bad++; $error("FAIL reset_mid_test obs=%b/%b exp=0/000", busy_test, lights);
    end
    run(20, 2'b00, 1'b0);
    // Randomised traffic against the model.
    w = 2'b00;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) w = 2'($urandom_range(0, 3));
      tr = ($urandom_range(0, 24) == 0);
      h  = ($urandom_range(0, 14) == 0);
      r  = ($urandom_range(0, 299) == 0);
      cyc(r, w, tr, h);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
